// File: rtl/fetch_flush_sequencer_pkg.sv
// Shared types for the fetch flush sequencer: flush reasons, sequencer FSM states and the address type.
package fetch_flush_sequencer_pkg;

    localparam int VADDR_WIDTH_DEFAULT = 32;

    typedef logic [VADDR_WIDTH_DEFAULT-1:0] vaddr_t;

    typedef enum logic [1:0] {
        FLUSH_NORMAL     = 2'd0,
        FLUSH_FENCE_I    = 2'd1,
        FLUSH_SFENCE_VMA = 2'd2
    } flush_reason_t;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        INV_ITLB   = 2'd1,
        INV_ICACHE = 2'd2
    } fetch_seq_state_t;

    // Maps a redirect reason to the invalidations it needs, packed as {itlb, icache}.
    function automatic logic [1:0] invalidate_request(input logic [1:0] reason);
        return {reason == FLUSH_SFENCE_VMA, reason == FLUSH_FENCE_I};
    endfunction

endpackage

// File: rtl/fetch_flush_sequencer_watchdog.sv
// Per-invalidation timeout counter; only built when FETCH_SEQ_TIMEOUT_EN is defined.
`ifdef FETCH_SEQ_TIMEOUT_EN
module fetch_flush_sequencer_watchdog #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rstN,
    input  logic active,
    input  logic done_hit,
    output logic expire,
    output logic timeout_error
);
    localparam int CountWidth = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CountWidth-1:0] LastCount = CountWidth'(TIMEOUT_CYCLES - 1);

    logic [CountWidth-1:0] count;

    // Fires at the end of the TIMEOUT_CYCLES-th cycle spent in one invalidation; a real done wins.
    assign expire = active && !done_hit && (count == LastCount);

    always_ff @(posedge clk) begin
        if (!rstN) begin
            count         <= '0;
            timeout_error <= 1'b0;
        end else begin
            if (!active || done_hit || expire) begin
                count <= '0;
            end else begin
                count <= count + 1'b1;
            end
            if (expire) begin
                timeout_error <= 1'b1;
            end
        end
    end

endmodule
`endif

// File: rtl/fetch_flush_sequencer.sv
// Fetch-pipe controller: merges stage stalls, issues a one-cycle flush with target PC, and sequences
// ITLB/ICache invalidation handshakes. Defining FETCH_SEQ_TIMEOUT_EN adds an invalidation watchdog.
module fetch_flush_sequencer
    import fetch_flush_sequencer_pkg::*;
#(
    parameter int VADDR_WIDTH    = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                   clk,
    input  logic                   rstN,
    input  logic                   flushFromMainPipe,
    input  logic [1:0]             flushReason,
    input  logic [VADDR_WIDTH-1:0] flushTargetPcFromMainPipe,
    input  logic                   stallFromICacheReadStage,
    input  logic                   stallFromInsnTraverseStage,
    input  logic                   invalidateITlbDone,
    input  logic                   invalidateICacheDone,
    output logic                   stall,
    output logic                   flush,
    output logic [VADDR_WIDTH-1:0] flushTargetPc,
    output logic                   invalidateITlb,
    output logic                   invalidateICache,
    output logic                   busy,
    output logic                   timeoutError
);

    fetch_seq_state_t state;
    logic             pend_itlb;
    logic             pend_icache;
    logic             set_itlb;
    logic             set_icache;
    logic             done_hit;
    logic             expire;
    logic             itlb_release;
    logic             icache_release;
    logic             next_pend_itlb;
    logic             next_pend_icache;

    // NOTE: every always_comb output gets a value on every path, so no latch can be inferred.
    always_comb begin
        {set_itlb, set_icache} = flushFromMainPipe ? invalidate_request(flushReason) : 2'b00;
        done_hit       = ((state == INV_ITLB)   && invalidateITlbDone) ||
                         ((state == INV_ICACHE) && invalidateICacheDone);
        itlb_release   = (state == INV_ITLB)   && (invalidateITlbDone   || expire);
        icache_release = (state == INV_ICACHE) && (invalidateICacheDone || expire);
        // Release clears first, then a same-cycle request of the same kind re-sets it (forces a re-run).
        next_pend_itlb   = (pend_itlb   && !itlb_release)   || set_itlb;
        next_pend_icache = (pend_icache && !icache_release) || set_icache;
    end

`ifdef FETCH_SEQ_TIMEOUT_EN
    fetch_flush_sequencer_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk          (clk),
        .rstN         (rstN),
        .active       (state != IDLE),
        .done_hit     (done_hit),
        .expire       (expire),
        .timeout_error(timeoutError)
    );
`else
    logic unused_timeout_cfg;
    assign expire             = 1'b0;
    assign timeoutError       = 1'b0;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0) ^ done_hit;
`endif

    // Busy covers the IDLE cycle in which a pend bit is already set, so stall has no gap.
    assign busy  = (state != IDLE) || pend_itlb || pend_icache;
    assign stall = stallFromICacheReadStage || stallFromInsnTraverseStage || busy;

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (!rstN) begin
            state            <= IDLE;
            pend_itlb        <= 1'b0;
            pend_icache      <= 1'b0;
            flush            <= 1'b0;
            flushTargetPc    <= '0;
            invalidateITlb   <= 1'b0;
            invalidateICache <= 1'b0;
        end else begin
            flush <= flushFromMainPipe;
            if (flushFromMainPipe) begin
                flushTargetPc <= flushTargetPcFromMainPipe;
            end
            pend_itlb   <= next_pend_itlb;
            pend_icache <= next_pend_icache;

            // Request outputs are registered together with the state, so they equal state==INV_*.
            case (state)
                IDLE: begin
                    if (pend_itlb) begin
                        state          <= INV_ITLB;
                        invalidateITlb <= 1'b1;
                    end else if (pend_icache) begin
                        state            <= INV_ICACHE;
                        invalidateICache <= 1'b1;
                    end
                end
                INV_ITLB: begin
                    if (itlb_release) begin
                        invalidateITlb <= 1'b0;
                        if (next_pend_icache) begin
                            state            <= INV_ICACHE;
                            invalidateICache <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                INV_ICACHE: begin
                    if (icache_release) begin
                        invalidateICache <= 1'b0;
                        if (next_pend_itlb) begin
                            state          <= INV_ITLB;
                            invalidateITlb <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state            <= IDLE;
                    invalidateITlb   <= 1'b0;
                    invalidateICache <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_flush_sequencer.sv
// Self-checking bench for fetch_flush_sequencer: directed scenarios plus randomized traffic vs a reference model.
module tb_fetch_flush_sequencer;
    import fetch_flush_sequencer_pkg::*;

    localparam int VW = 32;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rstN;
    logic          flushFromMainPipe;
    logic [1:0]    flushReason;
    logic [VW-1:0] flushTargetPcFromMainPipe;
    logic          stallFromICacheReadStage;
    logic          stallFromInsnTraverseStage;
    logic          invalidateITlbDone;
    logic          invalidateICacheDone;
    logic          stall;
    logic          flush;
    logic [VW-1:0] flushTargetPc;
    logic          invalidateITlb;
    logic          invalidateICache;
    logic          busy;
    logic          timeoutError;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model: outstanding work as two flags, plus the job currently served (0 none, 1 itlb, 2 icache).
    bit          m_pend_t;
    bit          m_pend_i;
    int          m_job;
    bit          m_flush;
    logic [VW-1:0] m_pc;
    bit          m_err;
`ifdef FETCH_SEQ_TIMEOUT_EN
    int          m_cnt;
`endif

    fetch_flush_sequencer #(
        .VADDR_WIDTH   (VW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk                       (clk),
        .rstN                      (rstN),
        .flushFromMainPipe         (flushFromMainPipe),
        .flushReason               (flushReason),
        .flushTargetPcFromMainPipe (flushTargetPcFromMainPipe),
        .stallFromICacheReadStage  (stallFromICacheReadStage),
        .stallFromInsnTraverseStage(stallFromInsnTraverseStage),
        .invalidateITlbDone        (invalidateITlbDone),
        .invalidateICacheDone      (invalidateICacheDone),
        .stall                     (stall),
        .flush                     (flush),
        .flushTargetPc             (flushTargetPc),
        .invalidateITlb            (invalidateITlb),
        .invalidateICache          (invalidateICache),
        .busy                      (busy),
        .timeoutError              (timeoutError)
    );

    always #5 clk = ~clk;

    task automatic drive_idle();
        flushFromMainPipe          = 1'b0;
        flushReason                = FLUSH_NORMAL;
        flushTargetPcFromMainPipe  = '0;
        stallFromICacheReadStage   = 1'b0;
        stallFromInsnTraverseStage = 1'b0;
        invalidateITlbDone         = 1'b0;
        invalidateICacheDone       = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rstN = 1'b0;
        drive_idle();
        repeat (2) next_cycle();
        tests_run++;
        if ({flush, invalidateITlb, invalidateICache, busy, stall, timeoutError} !== 6'b0) begin
            tests_failed++;
            $display("FAIL reset_outputs: flush/itlb/icache/busy/stall/err=%b required 000000",
                     {flush, invalidateITlb, invalidateICache, busy, stall, timeoutError});
        end
        tests_run++;
        if (flushTargetPc !== '0) begin
            tests_failed++;
            $display("FAIL reset_pc: got %h required 0", flushTargetPc);
        end
        rstN = 1'b1;
        repeat (2) next_cycle();
    endtask

    // Request on the inputs during cycle 10 -> flush only in cycle 11.
    task automatic test_normal_flush();
        tests_run++;
        if (flush !== 1'b0) begin
            tests_failed++;
            $display("FAIL normal_pre: flush=%b required 0", flush);
        end
        flushFromMainPipe         = 1'b1;
        flushReason               = FLUSH_NORMAL;
        flushTargetPcFromMainPipe = 32'h8000_0100;
        for (int c = 11; c <= 13; c++) begin
            next_cycle();
            flushFromMainPipe = 1'b0;
            tests_run++;
            if (flush !== (c == 11) || busy !== 1'b0) begin
                tests_failed++;
                $display("FAIL normal_flush cycle %0d: flush=%b busy=%b required %b 0", c, flush, busy, c == 11);
            end
            if (c == 11) begin
                tests_run++;
                if (flushTargetPc !== 32'h8000_0100) begin
                    tests_failed++;
                    $display("FAIL normal_pc: got %h required 80000100", flushTargetPc);
                end
            end
        end
    endtask

    // FENCE_I on the inputs in cycle 5, done in cycle 20.
    task automatic test_fence_i();
        tests_run++;
        if (stall !== 1'b0) begin
            tests_failed++;
            $display("FAIL fence_i_pre: stall=%b required 0", stall);
        end
        flushFromMainPipe         = 1'b1;
        flushReason               = FLUSH_FENCE_I;
        flushTargetPcFromMainPipe = 32'h8000_0200;
        for (int c = 6; c <= 21; c++) begin
            next_cycle();
            flushFromMainPipe = 1'b0;
            tests_run++;
            if (invalidateICache !== (c >= 7 && c <= 20) || stall !== (c <= 20) || invalidateITlb !== 1'b0) begin
                tests_failed++;
                $display("FAIL fence_i cycle %0d: icache=%b stall=%b itlb=%b required %b %b 0",
                         c, invalidateICache, stall, invalidateITlb, c >= 7 && c <= 20, c <= 20);
            end
            invalidateICacheDone = (c == 20);
        end
        invalidateICacheDone = 1'b0;
    endtask

    task automatic test_back_to_back();
        int overlap = 0, gap = 0, first_t = -1, first_i = -1, hi_t = 0, hi_i = 0;
        int served_t = 0, served_i = 0, cyc = 0;
        bit finished = 1'b0;
        flushFromMainPipe = 1'b1;
        flushReason       = FLUSH_SFENCE_VMA;
        next_cycle();
        flushReason       = FLUSH_FENCE_I;
        next_cycle();
        flushFromMainPipe = 1'b0;
        for (cyc = 2; cyc < 80 && !finished; cyc++) begin
            if (invalidateITlb && invalidateICache) overlap++;
            if (invalidateITlb && first_t < 0) first_t = cyc;
            if (invalidateICache && first_i < 0) first_i = cyc;
            if (!busy && (served_t == 0 || served_i == 0)) gap++;
            if (!busy && served_t > 0 && served_i > 0) finished = 1'b1;
            hi_t = invalidateITlb   ? hi_t + 1 : 0;
            hi_i = invalidateICache ? hi_i + 1 : 0;
            invalidateITlbDone   = (hi_t == 3);
            invalidateICacheDone = (hi_i == 3);
            if (invalidateITlbDone)   served_t++;
            if (invalidateICacheDone) served_i++;
            next_cycle();
        end
        invalidateITlbDone   = 1'b0;
        invalidateICacheDone = 1'b0;
        tests_run++;
        if (overlap != 0) begin
            tests_failed++;
            $display("FAIL b2b_overlap: %0d overlapping cycles required 0", overlap);
        end
        tests_run++;
        if (first_t < 0 || first_i <= first_t) begin
            tests_failed++;
            $display("FAIL b2b_order: itlb first at %0d icache first at %0d required itlb earlier", first_t, first_i);
        end
        tests_run++;
        if (gap != 0 || !finished || served_t != 1 || served_i != 1) begin
            tests_failed++;
            $display("FAIL b2b_busy: gap=%0d finished=%b served=%0d/%0d required 0 1 1/1",
                     gap, finished, served_t, served_i);
        end
    endtask

    task automatic test_stall_merge();
        stallFromInsnTraverseStage = 1'b1;
        flushFromMainPipe          = 1'b1;
        flushReason                = FLUSH_NORMAL;
        flushTargetPcFromMainPipe  = 32'h0000_1234;
        #1;
        tests_run++;
        if (stall !== 1'b1) begin
            tests_failed++;
            $display("FAIL stall_same_cycle: stall=%b required 1", stall);
        end
        next_cycle();
        flushFromMainPipe = 1'b0;
        tests_run++;
        if (flush !== 1'b1 || flushTargetPc !== 32'h0000_1234 || stall !== 1'b1) begin
            tests_failed++;
            $display("FAIL stall_flush: flush=%b pc=%h stall=%b required 1 00001234 1", flush, flushTargetPc, stall);
        end
        stallFromInsnTraverseStage = 1'b0;
        stallFromICacheReadStage   = 1'b1;
        #1;
        tests_run++;
        if (stall !== 1'b1) begin
            tests_failed++;
            $display("FAIL stall_icache_read: stall=%b required 1", stall);
        end
        stallFromICacheReadStage = 1'b0;
        #1;
        tests_run++;
        if (stall !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL stall_release: stall=%b busy=%b required 0 0", stall, busy);
        end
        next_cycle();
    endtask

    task automatic test_reset_mid_inv();
        int wait_cycles = 0;
        flushFromMainPipe = 1'b1;
        flushReason       = FLUSH_FENCE_I;
        next_cycle();
        flushFromMainPipe = 1'b0;
        while (!invalidateICache && wait_cycles < 20) begin
            next_cycle();
            wait_cycles++;
        end
        tests_run++;
        if (invalidateICache !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_mid_enter: icache=%b required 1 within 20 cycles", invalidateICache);
        end
        rstN = 1'b0;
        next_cycle();
        tests_run++;
        if ({flush, invalidateITlb, invalidateICache, busy, stall, timeoutError} !== 6'b0) begin
            tests_failed++;
            $display("FAIL reset_mid_outputs: flush/itlb/icache/busy/stall/err=%b required 000000",
                     {flush, invalidateITlb, invalidateICache, busy, stall, timeoutError});
        end
        rstN                 = 1'b1;
        invalidateICacheDone = 1'b1;
        next_cycle();
        invalidateICacheDone = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tests_run++;
            if (busy !== 1'b0 || invalidateICache !== 1'b0 || stall !== 1'b0) begin
                tests_failed++;
                $display("FAIL reset_mid_late_done: busy=%b icache=%b stall=%b required 0 0 0",
                         busy, invalidateICache, stall);
            end
            next_cycle();
        end
    endtask

    task automatic model_edge(input bit req, input logic [1:0] reason, input logic [VW-1:0] pc,
                              input bit dt, input bit di);
        bit new_t, new_i, hit, expired;
        new_t   = req && (reason == FLUSH_SFENCE_VMA);
        new_i   = req && (reason == FLUSH_FENCE_I);
        m_flush = req;
        if (req) m_pc = pc;
        expired = 1'b0;
        if (m_job == 0) begin
            // A waiting request starts on the next edge; one arriving now waits one cycle.
            m_job = m_pend_t ? 1 : (m_pend_i ? 2 : 0);
`ifdef FETCH_SEQ_TIMEOUT_EN
            m_cnt = 0;
`endif
            m_pend_t = m_pend_t | new_t;
            m_pend_i = m_pend_i | new_i;
        end else begin
            hit = (m_job == 1 && dt) || (m_job == 2 && di);
`ifdef FETCH_SEQ_TIMEOUT_EN
            expired = !hit && (m_cnt == TO - 1);
            m_cnt   = (hit || expired) ? 0 : m_cnt + 1;
            if (expired) m_err = 1'b1;
`endif
            if (hit || expired) begin
                if (m_job == 1) m_pend_t = 1'b0;
                else            m_pend_i = 1'b0;
                m_pend_t = m_pend_t | new_t;
                m_pend_i = m_pend_i | new_i;
                m_job = (m_job == 1) ? (m_pend_i ? 2 : 0) : (m_pend_t ? 1 : 0);
            end else begin
                m_pend_t = m_pend_t | new_t;
                m_pend_i = m_pend_i | new_i;
            end
        end
    endtask

    task automatic test_random();
        bit       exp_busy;
        bit [5:0] exp_vec;
        rstN = 1'b0;
        drive_idle();
        next_cycle();
        rstN     = 1'b1;
        m_pend_t = 1'b0;
        m_pend_i = 1'b0;
        m_job    = 0;
        m_flush  = 1'b0;
        m_pc     = '0;
        m_err    = 1'b0;
`ifdef FETCH_SEQ_TIMEOUT_EN
        m_cnt    = 0;
`endif
        for (int n = 0; n < 3000; n++) begin
            flushFromMainPipe          = ($urandom_range(0, 5) == 0);
            flushReason                = 2'($urandom_range(0, 2));
            flushTargetPcFromMainPipe  = $urandom;
            invalidateITlbDone         = (m_job == 1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 15) == 0);
            invalidateICacheDone       = (m_job == 2) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 15) == 0);
            stallFromICacheReadStage   = ($urandom_range(0, 4) == 0);
            stallFromInsnTraverseStage = ($urandom_range(0, 4) == 0);
            @(posedge clk);
            model_edge(flushFromMainPipe, flushReason, flushTargetPcFromMainPipe,
                       invalidateITlbDone, invalidateICacheDone);
            #1;
            exp_busy = (m_job != 0) || m_pend_t || m_pend_i;
            exp_vec  = {m_flush, m_job == 1, m_job == 2, exp_busy,
                        exp_busy || stallFromICacheReadStage || stallFromInsnTraverseStage, m_err};
            tests_run++;
            if ({flush, invalidateITlb, invalidateICache, busy, stall, timeoutError} !== exp_vec) begin
                tests_failed++;
                $display("FAIL random_outputs step %0d: flush/itlb/icache/busy/stall/err=%b required %b",
                         n, {flush, invalidateITlb, invalidateICache, busy, stall, timeoutError}, exp_vec);
            end
            if (m_flush) begin
                tests_run++;
                if (flushTargetPc !== m_pc) begin
                    tests_failed++;
                    $display("FAIL random_pc step %0d: got %h required %h", n, flushTargetPc, m_pc);
                end
            end
        end
        drive_idle();
    endtask

`ifdef FETCH_SEQ_TIMEOUT_EN
    task automatic test_timeout();
        int inv_cycles = 0, guard = 0;
        rstN = 1'b0;
        drive_idle();
        next_cycle();
        rstN              = 1'b1;
        flushFromMainPipe = 1'b1;
        flushReason       = FLUSH_FENCE_I;
        next_cycle();
        flushFromMainPipe = 1'b0;
        next_cycle();
        while (invalidateICache && guard < 100) begin
            inv_cycles++;
            guard++;
            next_cycle();
        end
        tests_run++;
        if (inv_cycles != TO) begin
            tests_failed++;
            $display("FAIL timeout_length: %0d invalidation cycles required %0d", inv_cycles, TO);
        end
        tests_run++;
        if (timeoutError !== 1'b1 || busy !== 1'b0 || stall !== 1'b0) begin
            tests_failed++;
            $display("FAIL timeout_state: err=%b busy=%b stall=%b required 1 0 0", timeoutError, busy, stall);
        end
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL global_time_limit: bench did not finish, required completion");
        $fatal(1);
    end

    initial begin
        rstN = 1'b0;
        drive_idle();
        #1;
        test_reset();
        test_normal_flush();
        test_fence_i();
        test_back_to_back();
        test_stall_merge();
        test_reset_mid_inv();
        test_random();
`ifdef FETCH_SEQ_TIMEOUT_EN
        test_timeout();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
